// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
// FSM state encoding and bit-period arithmetic used by uart_rx.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  function automatic int calc_cycles_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// The reset value is a parameter so idle-high and idle-low lines both come up quiet.
module sync_2ff #(
  parameter logic reset_value = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two capture stages; q is the second, metastability-settled stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= reset_value;
      q      <= reset_value;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver that pushes each good byte into the downstream fifo write port.
// Frame errors and fifo overruns are held in sticky flags until err_clear.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clk_freq   = 50_000_000,
  parameter int baud_rate  = 115_200,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [data_width-1:0] fifo_din,
  input  logic                  err_clear,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int cycles_per_bit = calc_cycles_per_bit(clk_freq, baud_rate);
  localparam int cnt_width      = $clog2(cycles_per_bit) + 1;
  localparam int idx_width      = (data_width > 1) ? $clog2(data_width) : 1;

  localparam logic [cnt_width-1:0] cnt_zero  = {cnt_width{1'b0}};
  localparam logic [cnt_width-1:0] cnt_one   = cnt_width'(1);
  localparam logic [cnt_width-1:0] half_last = cnt_width'(cycles_per_bit / 2 - 1);
  localparam logic [cnt_width-1:0] bit_last  = cnt_width'(cycles_per_bit - 1);
  localparam logic [idx_width-1:0] idx_zero  = {idx_width{1'b0}};
  localparam logic [idx_width-1:0] idx_one   = idx_width'(1);
  localparam logic [idx_width-1:0] idx_last  = idx_width'(data_width - 1);

  logic                  rx_s;
  rx_state_t             state_r, state_nx_s;
  logic [cnt_width-1:0]  cnt_r, cnt_run_s, cnt_nx_s;
  logic [idx_width-1:0]  idx_r, idx_nx_s;
  logic [data_width-1:0] shift_r, shift_nx_s;
  logic [data_width-1:0] din_nx_s;
  logic                  wr_en_nx_s, fe_nx_s, ov_nx_s;

  sync_2ff #(.reset_value(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  // Registers every piece of receiver state, including the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RX_IDLE;
      cnt_r       <= cnt_zero;
      idx_r       <= idx_zero;
      shift_r     <= {data_width{1'b0}};
      fifo_wr_en  <= 1'b0;
      fifo_din    <= {data_width{1'b0}};
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      idx_r       <= idx_nx_s;
      shift_r     <= shift_nx_s;
      fifo_wr_en  <= wr_en_nx_s;
      fifo_din    <= din_nx_s;
      frame_error <= fe_nx_s;
      overrun     <= ov_nx_s;
    end
  end

  // Next-state, counters, shift register and output next values.
  always_comb begin
    state_nx_s = state_r;
    cnt_run_s  = cnt_r + cnt_one;
    idx_nx_s   = idx_r;
    shift_nx_s = shift_r;
    wr_en_nx_s = 1'b0;
    din_nx_s   = fifo_din;
    // Clear first so a same-cycle set below wins.
    if (err_clear) begin
      fe_nx_s = 1'b0;
      ov_nx_s = 1'b0;
    end else begin
      fe_nx_s = frame_error;
      ov_nx_s = overrun;
    end

    case (state_r)
      RX_IDLE: begin
        idx_nx_s = idx_zero;
        if (!rx_s) begin
          state_nx_s = RX_START;
        end else begin
          state_nx_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == half_last) begin
          if (!rx_s) begin
            state_nx_s = RX_DATA;
          end else begin
            state_nx_s = RX_IDLE;
          end
        end else begin
          state_nx_s = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_r == bit_last) begin
          cnt_run_s  = cnt_zero;
          shift_nx_s = {rx_s, shift_r[data_width-1:1]};
          if (idx_r == idx_last) begin
            idx_nx_s   = idx_zero;
            state_nx_s = RX_STOP;
          end else begin
            idx_nx_s   = idx_r + idx_one;
          end
        end else begin
          state_nx_s = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_r == bit_last) begin
          if (rx_s) begin
            if (fifo_full) begin
              ov_nx_s = 1'b1;
            end else begin
              wr_en_nx_s = 1'b1;
              din_nx_s   = shift_r;
            end
            state_nx_s = RX_IDLE;
          end else begin
            fe_nx_s    = 1'b1;
            state_nx_s = RX_BREAK;
          end
        end else begin
          state_nx_s = RX_STOP;
        end
      end
      RX_BREAK: begin
        if (rx_s) begin
          state_nx_s = RX_IDLE;
        end else begin
          state_nx_s = RX_BREAK;
        end
      end
      default: begin
        state_nx_s = RX_IDLE;
      end
    endcase

    if (state_nx_s != state_r) begin
      cnt_nx_s = cnt_zero;
    end else begin
      cnt_nx_s = cnt_run_s;
    end
  end

endmodule
